// File: rtl/reaction_ctrl_pkg.sv
// Shared definitions for the reaction-time tester: controller state
// encoding (decoded by the timer stage), the overflow result value and
// the LFSR step function.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT     = 3'd1,
        CLR_CNT1 = 3'd2,
        START    = 3'd3,
        SHOW     = 3'd4,
        CLR_CNT2 = 3'd5,
        FOUL     = 3'd6
    } state_t;

    localparam logic [9:0] OVF_TIME = 10'd999;

    // 14-bit Fibonacci LFSR, taps 14/13/12/2, shifted left into bit 0.
    function automatic logic [13:0] lfsr_next(input logic [13:0] q);
        return {q[12:0], q[13] ^ q[12] ^ q[11] ^ q[1]};
    endfunction

endpackage

// File: rtl/reaction_ctrl_if.sv
// Controller <-> timer link.
//   machine_state : state code driven to the timer
//   rand_num      : latched pre-start delay in ms
//   signal_start / signal_overflow / signal_cleared : timer events
//   react_time    : timer count in START, in ms
// master = controller side, slave = timer side.
interface reaction_ctrl_if;
    logic [2:0]  machine_state;
    logic [13:0] rand_num;
    logic        signal_start;
    logic        signal_overflow;
    logic        signal_cleared;
    logic [9:0]  react_time;

    modport master (
        output machine_state, rand_num,
        input  signal_start, signal_overflow, signal_cleared, react_time
    );

    modport slave (
        input  machine_state, rand_num,
        output signal_start, signal_overflow, signal_cleared, react_time
    );
endinterface

// File: rtl/reaction_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, consecutive-sample filter and
// rising-edge pulse.
//   clk, rstn : clock, async active-low reset
//   btn       : raw button, asynchronous
//   press     : 1-cycle pulse on the debounced rising edge
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn,
    output logic press
);
    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1, sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          flip;

    // Flip on the edge where the DEB_CYCLES-th differing sample is seen.
    assign flip  = (sync2 != level) && (cnt == CW'(DEB_CYCLES - 1));
    // Decoded from registers only, so no btn-to-output path exists.
    assign press = flip && sync2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time tester control FSM. Debounces the button, drives the state
// code to the timer, latches the random pre-start delay and captures the
// result for the display.
//   clk, rstn     : 1 kHz clock, async active-low reset
//   btn           : raw push button
//   tmr           : timer link (machine_state, rand_num out; timer events in)
//   result        : captured reaction time (999 on overflow)
//   result_valid  : high in SHOW
//   overflow_flag : high in SHOW when the result came from overflow
//   false_start   : high in FOUL
//   led_go        : high in START
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 8,
    parameter int unsigned DELAY_BASE = 1000,
    parameter logic [13:0] LFSR_SEED  = 14'h0001
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   btn,
    reaction_ctrl_if.master        tmr,
    output logic [9:0]             result,
    output logic                   result_valid,
    output logic                   overflow_flag,
    output logic                   false_start,
    output logic                   led_go
);
    state_t      state_q, state_d;
    logic        press;
    logic        load_rand, cap_time, cap_ovf;
    logic [13:0] lfsr_q;
    logic [13:0] rand_q;
    logic [9:0]  result_q;
    logic        ovf_q;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clk),
        .rstn  (rstn),
        .btn   (btn),
        .press (press)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load_rand = 1'b0;
        cap_time  = 1'b0;
        cap_ovf   = 1'b0;
        case (state_q)
            IDLE: if (press) begin
                state_d   = CLR_CNT1;
                load_rand = 1'b1;
            end
            CLR_CNT1: if (tmr.signal_cleared) state_d = WAIT;
            WAIT: begin
                if (press)                 state_d = FOUL;
                else if (tmr.signal_start) state_d = START;
            end
            START: begin
                if (press) begin
                    state_d  = SHOW;
                    cap_time = 1'b1;
                end else if (tmr.signal_overflow) begin
                    state_d = SHOW;
                    cap_ovf = 1'b1;
                end
            end
            SHOW, FOUL: if (press) state_d = CLR_CNT2;
            CLR_CNT2: if (tmr.signal_cleared) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q   <= LFSR_SEED;
            rand_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
            if (load_rand) rand_q <= 14'(DELAY_BASE) + {2'b00, lfsr_q[11:0]};
            if (cap_time) begin
                result_q <= tmr.react_time;
                ovf_q    <= 1'b0;
            end else if (cap_ovf) begin
                result_q <= OVF_TIME;
                ovf_q    <= 1'b1;
            end
        end
    end

    assign tmr.machine_state = state_q;
    assign tmr.rand_num      = rand_q;
    assign result            = result_q;
    assign result_valid      = (state_q == SHOW);
    // ovf_q persists after SHOW; it only matters while the result is shown.
    assign overflow_flag     = ovf_q && (state_q == SHOW);
    assign false_start       = (state_q == FOUL);
    assign led_go            = (state_q == START);
endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl: cycle-level behavioural model in
// lockstep with the DUT, directed scenarios followed by random stimulus.
module tb_reaction_ctrl;
    localparam int DEB  = 8;
    localparam int BASE = 1000;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       btn = 1'b0;
    logic [9:0] result;
    logic       result_valid, overflow_flag, false_start, led_go;

    reaction_ctrl_if bus ();

    reaction_ctrl #(.DEB_CYCLES(DEB), .DELAY_BASE(BASE), .LFSR_SEED(14'h0001)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .btn           (btn),
        .tmr           (bus.master),
        .result        (result),
        .result_valid  (result_valid),
        .overflow_flag (overflow_flag),
        .false_start   (false_start),
        .led_go        (led_go)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model state: states numbered as IDLE=0 WAIT=1 CLR1=2 START=3 SHOW=4 CLR2=5 FOUL=6
    int ms, mrand, mres, mlfsr, clr_age;
    bit movf, mlev, s1m, s2m;
    bit samp[$];

    // Stimulus knobs
    bit ss, so, sc, auto_clr, ss_on_press, so_on_press;
    int rt;

    function automatic int lfsr_step(input int l);
        int fb;
        fb = ((l >> 13) ^ (l >> 12) ^ (l >> 11) ^ (l >> 1)) & 1;
        return ((l << 1) | fb) & 16'h3fff;
    endfunction

    // Level changes once DEB consecutive synchronized samples differ from it.
    function automatic bit would_flip();
        int n;
        if (s2m == mlev) return 1'b0;
        n = 1;
        for (int i = samp.size() - 1; i >= 0; i--) begin
            if (samp[i] != mlev) n++;
            else break;
        end
        return n >= DEB;
    endfunction

    task automatic model_reset();
        ms = 0; mrand = 0; mres = 0; movf = 0; mlfsr = 1; clr_age = 0;
        mlev = 0; s1m = 0; s2m = 0; samp.delete();
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_state"}, int'(bus.machine_state), ms);
        check({pfx, "_rand"},  int'(bus.rand_num), mrand);
        check({pfx, "_result"}, int'(result), mres);
        check({pfx, "_valid"}, int'(result_valid), int'(ms == 4));
        check({pfx, "_ovf"},   int'(overflow_flag), int'(ms == 4 && movf));
        check({pfx, "_foul"},  int'(false_start), int'(ms == 6));
        check({pfx, "_go"},    int'(led_go), int'(ms == 3));
    endtask

    task automatic cycle();
        bit p, fl;
        int nxt;
        p = would_flip() && !mlev;
        if (auto_clr) sc = (ms == 2 || ms == 5) && clr_age >= 1;
        if (ss_on_press) ss = p;
        if (so_on_press) so = p;
        bus.signal_start    = ss;
        bus.signal_overflow = so;
        bus.signal_cleared  = sc;
        bus.react_time      = 10'(rt);
        nxt = ms;
        case (ms)
            0: if (p) begin nxt = 2; mrand = BASE + (mlfsr & 12'hfff); end
            2: if (sc) nxt = 1;
            1: if (p) nxt = 6; else if (ss) nxt = 3;
            3: if (p) begin nxt = 4; mres = rt; movf = 0; end
               else if (so) begin nxt = 4; mres = 999; movf = 1; end
            4, 6: if (p) nxt = 5;
            5: if (sc) nxt = 0;
            default: nxt = 0;
        endcase
        clr_age = (nxt == ms) ? clr_age + 1 : 0;
        ms = nxt;
        mlfsr = lfsr_step(mlfsr);
        fl = would_flip();
        if (fl) begin
            mlev = ~mlev;
            samp.delete();
        end else begin
            samp.push_back(s2m);
            if (samp.size() > DEB) void'(samp.pop_front());
        end
        s2m = s1m;
        s1m = btn;
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    task automatic press_btn();
        btn = 1'b1;
        repeat (12) cycle();
        btn = 1'b0;
        repeat (12) cycle();
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        btn = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    int first_j, n_press, prev;
    int hold;

    initial begin
        ss = 0; so = 0; sc = 0; rt = 0;
        auto_clr = 1; ss_on_press = 0; so_on_press = 0;
        bus.signal_start = 0; bus.signal_overflow = 0;
        bus.signal_cleared = 0; bus.react_time = '0;
        model_reset();
        #1;
        check_outputs("por");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) cycle();

        // Normal run
        press_btn();
        check("norm_wait", int'(bus.machine_state), 1);
        check("norm_rand", int'(bus.rand_num), mrand);
        repeat (5) cycle();
        ss = 1; cycle(); ss = 0;
        check("norm_start", int'(led_go), 1);
        rt = 287;
        press_btn();
        check("norm_result", int'(result), 287);
        check("norm_valid", int'(result_valid), 1);
        check("norm_ovf", int'(overflow_flag), 0);

        // Overflow run
        press_btn();
        check("ovf_idle", int'(bus.machine_state), 0);
        press_btn();
        ss = 1; cycle(); ss = 0;
        rt = 999; so = 1; cycle(); so = 0;
        check("ovf_result", int'(result), 999);
        check("ovf_flag", int'(overflow_flag), 1);
        press_btn();
        check("ovf_back_idle", int'(bus.machine_state), 0);

        // False start
        press_btn();
        check("foul_wait", int'(bus.machine_state), 1);
        press_btn();
        check("foul_flag", int'(false_start), 1);
        check("foul_result_kept", int'(result), 999);
        press_btn();
        check("foul_idle", int'(bus.machine_state), 0);

        // Bouncing button: final rise at i=18, press expected 10 edges later
        first_j = -1; n_press = 0;
        for (int i = 0; i < 20; i++) begin
            btn = ((i / 3) % 2) == 0;
            prev = ms;
            cycle();
            if (bus.machine_state == 3'd2 && prev == 0) n_press++;
        end
        for (int j = 0; j < 20; j++) begin
            btn = 1'b1;
            prev = int'(bus.machine_state);
            cycle();
            if (bus.machine_state == 3'd2 && prev == 0) begin
                n_press++;
                if (first_j < 0) first_j = j;
            end
        end
        check("bounce_count", n_press, 1);
        check("bounce_latency", first_j, 7);
        btn = 1'b0;
        repeat (12) cycle();

        // Press together with signal_start in WAIT
        check("same_wait", int'(bus.machine_state), 1);
        ss_on_press = 1;
        press_btn();
        ss_on_press = 0; ss = 0;
        check("same_foul", int'(false_start), 1);
        press_btn();

        // Press together with signal_overflow in START
        press_btn();
        ss = 1; cycle(); ss = 0;
        rt = 555; so_on_press = 1;
        press_btn();
        so_on_press = 0; so = 0;
        check("same_result", int'(result), 555);
        check("same_ovf", int'(overflow_flag), 0);

        // Reset while in START
        press_btn();
        press_btn();
        ss = 1; cycle(); ss = 0;
        check("pre_rst_start", int'(bus.machine_state), 3);
        do_reset();
        repeat (5) cycle();
        check("lfsr_after_rst", int'(dut.lfsr_q), mlfsr);

        // Random stimulus
        auto_clr = 0;
        hold = 0;
        for (int k = 0; k < 4000; k++) begin
            if (hold == 0) begin
                btn = $urandom_range(1, 0);
                hold = $urandom_range(25, 1);
            end
            hold--;
            ss = ($urandom_range(7, 0) == 0);
            so = ($urandom_range(7, 0) == 0);
            sc = ($urandom_range(3, 0) == 0);
            rt = $urandom_range(1023, 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reaction_ctrl.md
# reaction_ctrl

Top-level control state machine of the reaction-time tester. It sits directly upstream of the timer stage. It debounces the single user button and drives the 3-bit `machine_state` bus that the timer decodes. It generates and latches the random pre-start delay `rand_num`, and consumes the timer's `signal_start` / `signal_overflow` / `signal_cleared` / `react_time` to capture the final result for the display stage. The design clock is the 1 kHz tick, so 1 cycle = 1 ms.

## Interface
- `DEB_CYCLES`, default 8: number of consecutive equal synchronized samples required to accept a button level change.
- `DELAY_BASE`, default 1000: minimum pre-start delay in cycles; `rand_num = DELAY_BASE + lfsr[11:0]`.
- `LFSR_SEED`, default 14'h0001: LFSR reset value; must be nonzero.
- `clk` in 1: 1 kHz system clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `btn` in 1: raw push button, active-high, asynchronous to `clk`.
- `signal_start` in 1: timer reached `rand_num` in WAIT.
- `signal_overflow` in 1: timer reached 999 in START.
- `signal_cleared` in 1: timer count equals 0.
- `react_time` in 10: timer count in START, in ms.
- `machine_state` out 3: current state encoding, driven to the timer.
- `rand_num` out 14: latched delay, stable from leaving IDLE until the next IDLE exit.
- `result` out 10: captured reaction time; 999 on overflow.
- `result_valid` out 1: high in SHOW only.
- `overflow_flag` out 1: high in SHOW when the result came from overflow.
- `false_start` out 1: high in FOUL only.
- `led_go` out 1: high in START only.

## Operation
- State encoding (3 bits): IDLE=0, WAIT=1, CLR_CNT1=2, START=3, SHOW=4, CLR_CNT2=5, FOUL=6. Code 7 is illegal and recovers to IDLE on the next edge.
- `press` is a 1-cycle pulse on the debounced rising edge of `btn`. Release edges are ignored.
- State transitions:
  - IDLE + press → CLR_CNT1. On that edge, `rand_num` ← `DELAY_BASE + lfsr[11:0]`, giving a range of 1000..5095.
  - CLR_CNT1 + `signal_cleared` → WAIT. Otherwise it stays in CLR_CNT1.
  - WAIT + press → FOUL. Press has priority over a simultaneous `signal_start`.
  - WAIT + `signal_start` → START.
  - START + press → SHOW, with `result` ← `react_time` and `overflow_flag` ← 0. Press has priority over a simultaneous `signal_overflow`.
  - START + `signal_overflow` → SHOW, with `result` ← 999 and `overflow_flag` ← 1.
  - SHOW + press → CLR_CNT2. FOUL + press → CLR_CNT2.
  - CLR_CNT2 + `signal_cleared` → IDLE.
- `result` holds its value through CLR_CNT2, IDLE and the next run until it is recaptured. `result_valid` is high only in SHOW.
- LFSR: 14-bit Fibonacci, taps 14/13/12/2. Feedback = q[13]^q[12]^q[11]^q[1], shifted left into bit 0. It advances every cycle in every state, so seed entropy comes from the user's press timing.
- Debounce: 2-flop synchronizer, then a counter. The counter resets whenever the synchronized sample equals the stable level. When it reaches `DEB_CYCLES-1` while the sample differs, the stable level flips.

## Timing
- Reset values:
  - Outputs: `machine_state`=IDLE, `rand_num`=0, `result`=0, `overflow_flag`=0, `result_valid`=0, `false_start`=0, `led_go`=0.
  - Internal: LFSR=`LFSR_SEED`, debounced level=0, synchronizers=0.
- All outputs are registered or are direct decodes of the state register. No input-to-output combinational path exists.
- Button latency: a clean `btn` rise gives a `press` 2 (sync) + `DEB_CYCLES` cycles later. The state changes on the edge at which `press` is high.
- Timer inputs are sampled on the same edge they are valid. For example, `signal_start` high in cycle N means `machine_state`=START from cycle N+1.
- Each CLR state lasts at least 1 cycle. The timer clears on the first CLR edge, so `signal_cleared` is normally seen on the 2nd CLR cycle.
- Reset mid-run: the block returns to IDLE immediately. No result is captured.

## Structure
- Shared package `reaction_pkg` holds the state encoding constants IDLE..FOUL, shared with the timer stage, plus `OVF_TIME`=999.
- One sub-module, `btn_debounce`, containing the synchronizer, filter counter and rising-edge pulse. The FSM, LFSR and result capture stay in `reaction_ctrl`.

## Test plan
- Normal run with LFSR forced so `rand_num`=1234: model timer asserts `signal_start` → START. Press with `react_time`=287 → SHOW, `result`=287, `result_valid`=1, `overflow_flag`=0.
- No press in START: `signal_overflow` at `react_time`=999 → SHOW, `result`=999, `overflow_flag`=1. A later press → CLR_CNT2, then IDLE once `signal_cleared` is seen.
- Press during WAIT before `signal_start` → FOUL, `false_start`=1, `result` unchanged. Press → CLR_CNT2 → IDLE.
- Bouncing `btn`: toggles every 3 cycles for 20 cycles, then held high. Exactly one `press` occurs, 2+8 cycles after the final rise.
- Same-cycle events: press together with `signal_start` in WAIT → FOUL. Press together with `signal_overflow` in START → `result`=`react_time`, `overflow_flag`=0.
- Reset asserted in START → all outputs at reset values asynchronously. The LFSR restarts at 14'h0001, and after 5 cycles equals the reference model's sequence.
